// File: rtl/fp_norm_pack24.sv
// Normalize-and-pack stage after the 24-bit significand add/sub: a carry
// costs one rounding cycle, leading zeros are removed one bit per cycle.
module fp_norm_pack24 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Sc,
  input  logic        cOut,
  input  logic [23:0] Mcps,
  input  logic [7:0]  Ec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;

  state_t             state;
  logic               s;
  logic signed [9:0]  e;
  logic [23:0]        m;
  logic               c;
  logic [24:0]        sum;

  // Right shift by one with round-to-nearest-even on the dropped bit.
  assign sum = {1'b1, m[23:1]} + {24'b0, m[0] & m[1]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      s      <= 1'b0;
      e      <= '0;
      m      <= '0;
      c      <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s     <= Sc;
          e     <= {2'b0, Ec};
          m     <= Mcps;
          c     <= cOut;
          state <= NORM;
        end
        NORM: begin
          if (c) begin
            c <= 1'b0;
            if (sum[24]) begin
              m <= sum[24:1];
              e <= e + 10'sd2;
            end else begin
              m <= sum[23:0];
              e <= e + 10'sd1;
            end
          end else if (m == 24'd0) begin
            result <= '0;
            zero   <= 1'b1;
            state  <= HOLD;
          end else if (m[23]) begin
            state <= HOLD;
            if (e >= 10'sd255) begin
              result <= {s, 8'hFF, 23'b0};
              ovf    <= 1'b1;
            end else if (e == 10'sd0) begin
              result <= {s, 31'b0};
              unf    <= 1'b1;
            end else begin
              result <= {s, e[7:0], m[22:0]};
            end
          end else if (e <= 10'sd1) begin
            // Would need a denormal; flush to signed zero instead.
            result <= {s, 31'b0};
            unf    <= 1'b1;
            state  <= HOLD;
          end else begin
            m <= m << 1;
            e <= e - 10'sd1;
          end
        end
        HOLD: if (out_ready) begin
          result <= '0;
          ovf    <= 1'b0;
          unf    <= 1'b0;
          zero   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_pack24.sv
// Randomized self-checking bench for fp_norm_pack24 against an arithmetic
// reference model of normalize/round/pack, including latency and handshake.
module tb_fp_norm_pack24;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        Sc;
  logic        cOut;
  logic [23:0] Mcps;
  logic [7:0]  Ec;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf, unf, zero;

  int total = 0;
  int bad   = 0;

  fp_norm_pack24 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Sc(Sc), .cOut(cOut), .Mcps(Mcps), .Ec(Ec),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ovf(ovf), .unf(unf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: value-level normalize with integer arithmetic.
  task automatic model(input logic sc, input logic co, input logic [23:0] mi, input logic [7:0] ei,
                       output logic [31:0] res, output logic o, output logic u, output logic z,
                       output int lat);
    int unsigned sig;
    int          ex;
    logic [7:0]  e8;
    logic [22:0] f23;
    sig = mi; ex = ei; lat = 1; o = 0; u = 0; z = 0; res = 0;
    if (co) begin
      // value = (2^24 + mi) / 2^23; halve it, rounding the lost bit to even
      sig = (sig >> 1) + 32'h0080_0000;
      if ((mi[0] == 1'b1) && (sig % 2 == 1)) sig = sig + 1;
      ex = ex + 1;
      if (sig >= 32'h0100_0000) begin sig = sig / 2; ex = ex + 1; end
      lat = 2;
    end
    if (sig == 0) begin
      z = 1;
    end else begin
      while (sig < 32'h0080_0000 && ex > 1) begin sig = sig * 2; ex = ex - 1; lat++; end
      if (sig >= 32'h0080_0000) begin
        if (ex >= 255) begin o = 1; res = {sc, 8'hFF, 23'b0}; end
        else if (ex == 0) begin u = 1; res = {sc, 31'b0}; end
        else begin e8 = ex[7:0]; f23 = sig[22:0]; res = {sc, e8, f23}; end
      end else begin
        u = 1; res = {sc, 31'b0};
      end
    end
  endtask

  task automatic launch(input logic sc, input logic co, input logic [23:0] mi, input logic [7:0] ei);
    int w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); @(negedge clk); w++; end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    Sc = sc; cOut = co; Mcps = mi; Ec = ei; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    Sc = 1'($urandom); cOut = 1'($urandom); Mcps = 24'($urandom); Ec = 8'($urandom);
  endtask

  task automatic run_txn(input logic sc, input logic co, input logic [23:0] mi, input logic [7:0] ei,
                         input int hold);
    logic [31:0] er;
    logic eo, eu, ez;
    int el, lat;
    logic [31:0] r0;
    model(sc, co, mi, ei, er, eo, eu, ez, el);
    out_ready = 1'b0;
    launch(sc, co, mi, ei);
    chk("busy_after_accept", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
    chk("latency", lat, el);
    chk("result", result, er);
    chk("flags", {29'b0, ovf, unf, zero}, {29'b0, eo, eu, ez});
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", result, r0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd1);
    chk("post_clear", {result[31:3], result[2:0] | {ovf, unf, zero}}, 32'd0);
  endtask

  initial begin
    logic [23:0] rm;
    logic [7:0]  re;
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Sc = 0; cOut = 0; Mcps = 0; Ec = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'b0, ovf, unf, zero}, 32'd0);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_txn(0, 0, 24'h800000, 8'h7F, 0);
    run_txn(0, 1, 24'h800000, 8'h7F, 0);
    run_txn(0, 1, 24'hFFFFFF, 8'h7F, 1);
    run_txn(1, 0, 24'h000000, 8'h55, 0);
    run_txn(0, 0, 24'h000001, 8'h7F, 0);
    run_txn(1, 1, 24'h000000, 8'hFE, 2);
    run_txn(0, 0, 24'h100000, 8'h02, 0);
    run_txn(1, 1, 24'h000003, 8'h10, 5);
    run_txn(0, 0, 24'h800000, 8'h00, 0);
    run_txn(0, 0, 24'h000004, 8'h00, 0);

    // Reset mid-NORM: nothing emitted, next transaction clean.
    out_ready = 1'b1;
    launch(0, 0, 24'h000001, 8'h7F);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rstnorm_valid", 32'(out_valid), 32'd0);
    chk("rstnorm_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    lat = 0;
    repeat (30) begin @(posedge clk); #1 if (out_valid) lat++; end
    chk("rstnorm_no_output", lat, 0);
    run_txn(0, 0, 24'h400000, 8'h80, 0);

    // Reset in HOLD clears result asynchronously.
    out_ready = 1'b0;
    launch(1, 0, 24'h800000, 8'h7F);
    @(posedge clk); #2 chk("hold_pre_rst", result, 32'hBF800000);
    rst = 1'b1;
    #1 chk("rsthold_result", result, 32'd0);
    chk("rsthold_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_txn(0, 1, 24'h7FFFFF, 8'hFD, 0);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: re = 8'($urandom_range(0, 3));
        1: re = 8'($urandom_range(250, 255));
        default: re = 8'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: rm = 24'h0;
        1: rm = 24'hFFFFFF;
        2: rm = 24'($urandom) | 24'h800000;
        default: rm = 24'($urandom) >> $urandom_range(0, 23);
      endcase
      run_txn(1'($urandom), 1'($urandom), rm, re, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
